// File: rtl/arith_pipe_if.sv
// arith_pipe_if -- handshake/data bundle for arith_pipe.
//   Operand side : in_valid, in_ready, op, a, b
//   Result side  : out_valid, out_ready, z, ovf, done_cnt
// The slave modport is the arithmetic unit; master is the surrounding logic
// (operand source plus result consumer).
interface arith_pipe_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] z;
    logic                  ovf;
    logic [CNT_WIDTH-1:0]  done_cnt;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, z, ovf, done_cnt
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, z, ovf, done_cnt
    );
endinterface

// File: rtl/arith_pipe.sv
// arith_pipe -- elastic two-operand arithmetic unit (add/sub/min/max) with a
// configurable number of register stages and valid/ready on both sides.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : arith_pipe_if.slave (operand handshake, result handshake,
//          completed-transaction counter)
// Optional feature: define ARITH_PIPE_SAT_EN to saturate add/sub results
// (carry -> all-ones, borrow -> zero); ovf is reported either way.
module arith_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rstn,
    arith_pipe_if.slave  bus
);

    localparam int unsigned W = DATA_WIDTH;

    // Per-stage state
    logic [STAGES-1:0]        v_q;
    logic [STAGES-1:0][W-1:0] z_q;
    logic [STAGES-1:0]        ovf_q;
    logic [CNT_WIDTH-1:0]     cnt_q;

    // Per-stage load enable and upstream source
    logic [STAGES-1:0]        ld;
    logic [STAGES-1:0]        up_v;
    logic [STAGES-1:0][W-1:0] up_z;
    logic [STAGES-1:0]        up_ovf;

    // Stage-0 arithmetic
    logic [W:0]   sum_w;
    logic [W:0]   dif_w;
    logic [W-1:0] res_z;
    logic         res_ovf;

    always_comb begin
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        dif_w   = {1'b0, bus.a} - {1'b0, bus.b};
        res_z   = '0;
        res_ovf = 1'b0;
        case (bus.op)
            2'b00: begin
                res_z   = sum_w[W-1:0];
                res_ovf = sum_w[W];
`ifdef ARITH_PIPE_SAT_EN
                if (sum_w[W]) res_z = '1;
`endif
            end
            2'b01: begin
                res_z   = dif_w[W-1:0];
                res_ovf = dif_w[W];
`ifdef ARITH_PIPE_SAT_EN
                if (dif_w[W]) res_z = '0;
`endif
            end
            2'b10:   res_z = (bus.a <= bus.b) ? bus.a : bus.b;
            default: res_z = (bus.a >= bus.b) ? bus.a : bus.b;
        endcase
    end

    // A stage may load when it, or any stage after it, holds a bubble, or
    // when the consumer is taking the output. Flattening the recursive
    // !v[i] || ld[i+1] chain this way keeps ld free of self-reference.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        ld       = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            all_full             = all_full & v_q[STAGES-1-k];
            ld[STAGES-1-k]       = !all_full || bus.out_ready;
        end
    end

    always_comb begin
        up_v      = '0;
        up_z      = '0;
        up_ovf    = '0;
        up_v[0]   = bus.in_valid;
        up_z[0]   = res_z;
        up_ovf[0] = res_ovf;
        for (int unsigned k = 1; k < STAGES; k++) begin
            up_v[k]   = v_q[k-1];
            up_z[k]   = z_q[k-1];
            up_ovf[k] = ovf_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q   <= '0;
            z_q   <= '0;
            ovf_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= up_v[k];
                    // Bubbles leave the payload untouched
                    if (up_v[k]) begin
                        z_q[k]   <= up_z[k];
                        ovf_q[k] <= up_ovf[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (v_q[STAGES-1] && bus.out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.z         = z_q[STAGES-1];
    assign bus.ovf       = ovf_q[STAGES-1];
    assign bus.done_cnt  = cnt_q;

endmodule

// File: doc/arith_pipe.md
# arith_pipe

Parametrised, elastic two-operand arithmetic unit: accepts operands `a`, `b` and an opcode under a valid/ready handshake. Produces the result `z` and an overflow flag after a configurable number of register stages. It is the pipelined, handshaked successor to the single-cycle combinational `a`/`b` → `z` datapath sub-blocks. It is instantiated the same way, between an operand source and a result consumer that can each stall.

## Interface
- `DATA_WIDTH`, 16, operand/result width in bits (≥ 2).
- `STAGES`, 2, number of register stages from input to output (1..4).
- `CNT_WIDTH`, 16, width of the completed-transaction counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  unit can accept a beat this cycle.
- `op`  in  2  00 add, 01 sub (a−b), 10 unsigned min, 11 unsigned max.
- `a`, `b`  in  DATA_WIDTH each  unsigned operands.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts result.
- `z`  out  DATA_WIDTH  result.
- `ovf`  out  1  add carry-out / sub borrow; 0 for min/max.
- `done_cnt`  out  CNT_WIDTH  count of completed output handshakes.

## Operation
- Input handshake: a beat is accepted on the cycle where `in_valid && in_ready`. Output handshake: a beat is consumed on the cycle where `out_valid && out_ready`.
- Stage 0 registers the computed result. Stages 1..STAGES−1 only carry `{z, ovf}` and a per-stage valid bit `v[i]`.
- Arithmetic is computed at DATA_WIDTH+1 bits:
  - add: z = (a+b) mod 2^W, ovf = carry.
  - sub: z = (a−b) mod 2^W, ovf = (a<b).
  - min/max: unsigned compare; ties return `a`; ovf = 0.
- Stage advance: stage i loads from stage i−1 (or the input, for i=0) when `!v[i] || adv[i+1]`. `adv[STAGES]` = `out_ready`.
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- `in_ready` = `!v[0] || adv[1]`. It is combinational from `out_ready` through the chain; `in_valid` is not in that path.
- Stalled data is held stable: `z`/`ovf` must not change while `out_valid && !out_ready`.
- `done_cnt` increments by 1 on each output handshake and saturates at 2^CNT_WIDTH−1 (no wrap).
- `op`, `a`, `b` are don't-care when `in_valid` = 0.

## Timing
- Latency: an input accepted at cycle t presents `out_valid` at t+STAGES, provided no stall.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Capacity: at most STAGES beats in flight. When all `v[i]` = 1 and `out_ready` = 0, `in_ready` = 0.
- Simultaneous accept and consume while full: allowed. `in_ready` = 1 when `out_ready` = 1, and occupancy is unchanged.
- Reset values:
  - all `v[i]` = 0, so `out_valid` = 0 and `in_ready` = 1 (comb.).
  - `z` = 0, `ovf` = 0, `done_cnt` = 0.
- Reset mid-operation: in-flight beats are discarded and not counted; outputs go to reset values asynchronously.
- First accept is possible on the first rising edge after `rstn` deasserts.

## Configuration
- `ARITH_PIPE_SAT_EN` defined: add/sub saturate.
  - Add with carry → z = all-ones.
  - Sub with borrow → z = 0.
  - `ovf` is still reported; min/max are unaffected.
- `ARITH_PIPE_SAT_EN` undefined: add/sub wrap modulo 2^DATA_WIDTH as described above. No saturation logic is synthesised.

## Test plan
All scenarios use DATA_WIDTH=8, STAGES=2, CNT_WIDTH=4 unless noted.
- Reset/idle: hold `rstn`=0, then release → `out_valid`=0, `in_ready`=1, `z`=0, `done_cnt`=0. The first beat, add 3+4, is accepted at t and gives `out_valid` at t+2 with z=7, ovf=0.
- Overflow:
  - add 200+100 → z=44, ovf=1 (wrap build); z=255, ovf=1 (SAT build).
  - sub 5−9 → z=252, ovf=1 (wrap); z=0, ovf=1 (SAT).
- Min/max: min(9,200)=9, max(9,200)=200, min(7,7)=7, all with ovf=0.
- Back-pressure: stream 4 beats with `out_ready`=0.
  - 2 accepted, then `in_ready`=0; `z` stays stable.
  - Raise `out_ready` → all 4 delivered in order, one per cycle, with no loss or duplication. Bubble inserted mid-stream collapses.
- Counter saturation: 20 output handshakes → `done_cnt`=15, held.
- Reset mid-flight: assert `rstn`=0 with 2 beats in flight → `out_valid`=0 immediately, `done_cnt`=0, and no stale beat appears after release.
